systolic_2x2_sequencer: RTL

Control and drain engine for the 2x2 weight-stationary-free systolic matrix unit. On a start request it clears the PE accumulators and drives the skewed operand-select schedule (data_valid, a*_sel, b*_sel) so the array computes C = A x B (or A x B^T). It then waits for pipeline drain, captures the four 16-bit results, and streams them out one per beat over a valid/ready interface toward the memory write path.

---
 rtl/systolic_2x2_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/systolic_2x2_sequencer.sv
// Sequencer for the 2x2 systolic matrix unit: clears the PE accumulators, drives the skewed
// operand-select schedule, waits for drain, captures the four results and streams them out.
module systolic_2x2_sequencer #(
    parameter int DRAIN_CYCLES = 2,
    parameter int RES_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 transpose_in,
    input  logic                 relu_in,
    input  logic                 accumulate_in,
    output logic                 busy,
    output logic                 done,
    output logic                 clear,
    output logic                 data_valid,
    output logic [1:0]           a0_sel,
    output logic [1:0]           a1_sel,
    output logic [1:0]           b0_sel,
    output logic [1:0]           b1_sel,
    output logic                 transpose,
    output logic                 activation,
    input  logic [RES_WIDTH-1:0] c00,
    input  logic [RES_WIDTH-1:0] c01,
    input  logic [RES_WIDTH-1:0] c10,
    input  logic [RES_WIDTH-1:0] c11,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RES_WIDTH-1:0] out_data,
    output logic [1:0]           out_idx,
    output logic                 out_last
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED0,
        FEED1,
        FEED2,
        DRAIN,
        CAPTURE,
        SEND
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CW-1:0]          drain_cnt;
    logic                   accumulate_q;
    logic [RES_WIDTH-1:0]   cap00;
    logic [RES_WIDTH-1:0]   cap01;
    logic [RES_WIDTH-1:0]   cap10;
    logic [RES_WIDTH-1:0]   cap11;
    logic                   last_handshake;

    assign last_handshake = (state == SEND) && out_ready && (out_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            accumulate_q <= 1'b0;
            transpose    <= 1'b0;
            activation   <= 1'b0;
            done         <= 1'b0;
            out_idx      <= 2'd0;
            cap00        <= '0;
            cap01        <= '0;
            cap10        <= '0;
            cap11        <= '0;
        end else begin
            state <= next_state;
            done  <= last_handshake;
            if (state == IDLE && start) begin
                transpose    <= transpose_in;
                activation   <= relu_in;
                accumulate_q <= accumulate_in;
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + CW'(1);
            end else begin
                drain_cnt <= '0;
            end
            // Results are frozen here so later array activity cannot disturb the output stream.
            if (state == CAPTURE) begin
                cap00   <= c00;
                cap01   <= c01;
                cap10   <= c10;
                cap11   <= c11;
                out_idx <= 2'd0;
            end
            if (state == SEND && out_ready) begin
                out_idx <= out_idx + 2'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        clear      = 1'b0;
        data_valid = 1'b0;
        a0_sel     = 2'd2;
        a1_sel     = 2'd2;
        b0_sel     = 2'd2;
        b1_sel     = 2'd2;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                clear      = !accumulate_q;
                next_state = FEED0;
            end
            // Row 1 and column 1 lag by one beat to match the PE-to-PE register hop.
            FEED0: begin
                data_valid = 1'b1;
                a0_sel     = 2'd0;
                b0_sel     = 2'd0;
                next_state = FEED1;
            end
            FEED1: begin
                data_valid = 1'b1;
                a0_sel     = 2'd1;
                a1_sel     = 2'd0;
                b0_sel     = 2'd1;
                b1_sel     = 2'd0;
                next_state = FEED2;
            end
            FEED2: begin
                data_valid = 1'b1;
                a1_sel     = 2'd1;
                b1_sel     = 2'd1;
                next_state = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == CW'(DRAIN_CYCLES - 1)) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                next_state = SEND;
            end
            SEND: begin
                if (last_handshake) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && (out_idx == 2'd3);

    always_comb begin
        out_data = cap00;
        case (out_idx)
            2'd0: out_data = cap00;
            2'd1: out_data = cap01;
            2'd2: out_data = cap10;
            2'd3: out_data = cap11;
            default: out_data = cap00;
        endcase
    end

endmodule
